lev_multicycle_sequencer: RTL and testbench
===========================================

// Module: lev_multicycle_sequencer
// PURPOSE
// Parametrised next-generation control sequencer for the multicycle LEGv8-style datapath.
// Classifies IR, walks FETCH/DECODE/EXEC/MEM/WB, generates the DATA_W-wide constant k,
// evaluates branch conditions, and handshakes with memory. Adds a fetch/memory stall
// handshake, a timeout fault and illegal-encoding detection.
// PARAMETERS
// DATA_W       64   datapath/k width; legal values 32 or 64
// MEM_TIMEOUT  15   max wait cycles for mem_ready; 0 = wait forever
// PORTS
// clock       in   1       system clock, rising edge
// reset       in   1       asynchronous, active-low; 0 forces reset state immediately
// IR          in   32      instruction word; read only in DECODE
// status      in   4       {N,Z,C,V} flags, registered in the datapath
// zero        in   1       ALU result==0, used by CBZ/CBNZ in EXEC
// mem_ready   in   1       memory completes the current request this cycle
// state       out  3       0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 FAULT
// mem_req     out  1       memory request; high in FETCH and MEM
// mem_write   out  1       store; valid only with mem_req in MEM
// ir_load     out  1       latch IR; pulses in the FETCH cycle where mem_ready=1
// reg_write   out  1       register file write enable
// status_load out  1       flag update; high in EXEC for ADDS/SUBS/ADDIS/SUBIS/ANDS/ANDIS
// pc_sel      out  2       00 hold, 01 PC+4, 10 PC+k, 11 register (BR)
// k           out  DATA_W  immediate/offset constant, held from DECODE until next DECODE
// illegal     out  1       sticky; unknown class or out-of-range immediate
// BEHAVIOUR
// - Reset: state=FETCH, k=0, illegal=0, timeout counter=0. All strobes are 0 whenever reset=0.
// - Strobes (mem_req aside) are Moore outputs of state plus the decoded class latched in DECODE.
// - Class decode, IR[28:25]: 100x DP-imm; 101x branch; x1x0 load/store; x101 DP-reg;
//   anything else sets illegal and goes to FAULT.
// - FETCH: mem_req=1.
//   - mem_ready=0: stay in FETCH.
//   - mem_ready=1: ir_load=1, then DECODE.
// - DECODE: latch class, compute k, then EXEC. Always exactly 1 cycle.
// - EXEC outcomes:
//   - DP: reg_write=1, pc_sel=01, then FETCH.
//   - Branch: pc_sel=10 if taken, 01 if not; BR uses 11. Then FETCH.
//   - BL: additionally reg_write=1 for X30.
//   - Load/store: pc_sel=01, then MEM.
// - MEM: mem_req=1, mem_write=1 for stores.
//   - mem_ready=0: stay in MEM.
//   - mem_ready=1, store: then FETCH.
//   - mem_ready=1, load: then WB.
// - WB: reg_write=1, then FETCH. Instruction latency with zero-wait memory:
//   DP/branch 3 cycles, store 4, load 5.
// - Timeout: the counter resets on entry to FETCH/MEM and counts while mem_ready=0.
//   Reaching MEM_TIMEOUT moves to FAULT. FAULT drives all strobes 0 and exits only via reset.
//   mem_ready in the same cycle as the terminal count wins: no fault.
// - k rules: all fields are zero-extended unless marked sign-extended.
//   - ADDI/SUBI/logic: imm12 IR[21:10].
//   - MOVZ/MOVK: IR[20:5] << (16*IR[22:21]); with DATA_W=32, IR[22]=1 is illegal.
//   - LSL/LSR: shamt IR[15:10]; shamt >= DATA_W is illegal.
//   - B/BL: sign-extended IR[25:0] << 2.
//   - CBZ/CBNZ/B.cond: sign-extended IR[23:5] << 2.
//   - Load/store: sign-extended IR[20:12].
// - B.cond on IR[3:0]:
//   - Pairs: EQ Z/NE !Z; HS C/LO !C; MI N/PL !N; VS V/VC !V; HI C&!Z / LS its inverse.
//   - Signed: GE N==V / LT N!=V; GT !Z&(N==V) / LE its inverse; 1110/1111 always taken.
// - CBZ: taken when zero=1. CBNZ: taken when zero=0.
// - An illegal encoding sets illegal in DECODE and enters FAULT the next edge.
// - Reset asserted mid-MEM/WB aborts with no strobe glitch; state returns to FETCH asynchronously.
// TESTING
// - LSR: IR={11'b11010011010,5'd31,6'd2,5'd31,5'd0}, mem_ready=1 ->
//   states 0,1,2,0; k=2; reg_write=1 only in EXEC.
// - MOVK hw=3, imm16=16'hBEEF: DATA_W=64 -> k=64'hBEEF_0000_0000_0000;
//   DATA_W=32 -> illegal=1, state=7.
// - B.cond GT with imm19=-1: status=4'b0000 -> pc_sel=10, k=-4;
//   status=4'b0100 -> pc_sel=01.
// - LDUR with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, then WB with reg_write=1,
//   then FETCH.
// - MEM_TIMEOUT=4, mem_ready stuck low in FETCH -> FAULT after 4 cycles,
//   strobes 0 until reset.
// - reset pulsed low during MEM -> state=0 and mem_req=0 with no clock edge;
//   normal fetch resumes after release.

Source files
------------

// File: rtl/lev_multicycle_sequencer.sv
// lev_multicycle_sequencer: multicycle LEGv8 control sequencer with memory stall, timeout fault and illegal detect
//   in : clock, reset (async, active-low), IR[31:0], status {N,Z,C,V}, zero, mem_ready
//   out: state[2:0] (0 FETCH,1 DECODE,2 EXEC,3 MEM,4 WB,7 FAULT), mem_req, mem_write, ir_load,
//        reg_write, status_load, pc_sel[1:0] (00 hold,01 PC+4,10 PC+k,11 reg), k[DATA_W-1:0], illegal
module lev_multicycle_sequencer #(
    parameter int DATA_W      = 64,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       IR,
    input  logic [3:0]        status,
    input  logic              zero,
    input  logic              mem_ready,
    output logic [2:0]        state,
    output logic              mem_req,
    output logic              mem_write,
    output logic              ir_load,
    output logic              reg_write,
    output logic              status_load,
    output logic [1:0]        pc_sel,
    output logic [DATA_W-1:0] k,
    output logic              illegal
);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, FAULT = 3'd7;
    localparam logic [15:0] LAST = 16'(MEM_TIMEOUT - 1);

    logic c_dpi, c_br, c_ls, c_dpr, is_mov, is_shift, is_b, is_cb, is_bc, is_brr, d_flags, bad_imm, d_illegal;
    logic [63:0] k64;
    logic [15:0] cnt;
    logic [2:0] nxt;
    logic r_dp, r_ls, r_store, r_uncond, r_bl, r_cb, r_cbnz, r_bc, r_brr, r_flags;
    logic [3:0] r_cond;
    logic n_f, z_f, c_f, v_f, cond_base, taken, expired, run;

    // class from IR[28:25]; the four patterns are mutually exclusive
    assign c_dpi = IR[28:26] == 3'b100;
    assign c_br  = IR[28:26] == 3'b101;
    assign c_ls  = IR[27] & ~IR[25];
    assign c_dpr = IR[27:25] == 3'b101;

    assign is_mov   = c_dpi && (IR[31:23] == 9'b110100101 || IR[31:23] == 9'b111100101);
    assign is_shift = c_dpi && IR[31:22] == 10'b1101001101;
    assign is_b     = c_br && IR[30:26] == 5'b00101;
    assign is_cb    = c_br && IR[31:25] == 7'b1011010;
    assign is_bc    = c_br && IR[31:24] == 8'b01010100;
    assign is_brr   = c_br && !is_b && !is_cb && !is_bc;
    // ORR/ORRI share IR[29] with the S forms, so flag setters are matched exactly
    assign d_flags  = (c_dpi && IR[31:22] inside {10'b1011000100, 10'b1111000100, 10'b1111001000})
                   || (c_dpr && IR[31:21] inside {11'b10101011000, 11'b11101011000, 11'b11101010000});
    assign bad_imm  = (is_mov && DATA_W == 32 && IR[22]) || (is_shift && 32'(IR[15:10]) >= DATA_W);
    assign d_illegal = !(c_dpi || c_br || c_ls || c_dpr) || bad_imm;

    // built 64 bits wide then truncated, so sign extension is right for either DATA_W
    assign k64 = is_mov   ? {48'b0, IR[20:5]} << {IR[22:21], 4'b0} :
                 is_shift ? {58'b0, IR[15:10]} :
                 c_dpi    ? {52'b0, IR[21:10]} :
                 is_b     ? {{36{IR[25]}}, IR[25:0], 2'b00} :
                 (is_cb || is_bc) ? {{43{IR[23]}}, IR[23:5], 2'b00} :
                 c_ls     ? {{55{IR[20]}}, IR[20:12]} : 64'b0;

    assign {n_f, z_f, c_f, v_f} = status;
    assign cond_base = r_cond[3:1] == 3'd0 ? z_f :
                       r_cond[3:1] == 3'd1 ? c_f :
                       r_cond[3:1] == 3'd2 ? n_f :
                       r_cond[3:1] == 3'd3 ? v_f :
                       r_cond[3:1] == 3'd4 ? (c_f & ~z_f) :
                       r_cond[3:1] == 3'd5 ? (n_f == v_f) :
                       r_cond[3:1] == 3'd6 ? (~z_f & (n_f == v_f)) : 1'b0;
    // odd codes invert the even ones; 1110/1111 are always taken
    assign taken = r_uncond | (r_cb & (zero ^ r_cbnz)) | (r_bc & ((&r_cond[3:1]) | (cond_base ^ r_cond[0])));

    assign expired = MEM_TIMEOUT != 0 && cnt == LAST;
    assign nxt = state == FETCH  ? (mem_ready ? DECODE : expired ? FAULT : FETCH) :
                 state == DECODE ? (d_illegal ? FAULT : EXEC) :
                 state == EXEC   ? (r_ls ? MEM : FETCH) :
                 state == MEM    ? (mem_ready ? (r_store ? FETCH : WB) : expired ? FAULT : MEM) :
                 state == WB     ? FETCH : FAULT;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state    <= FETCH;
            k        <= '0;
            illegal  <= 1'b0;
            cnt      <= '0;
            r_dp     <= 1'b0;
            r_ls     <= 1'b0;
            r_store  <= 1'b0;
            r_uncond <= 1'b0;
            r_bl     <= 1'b0;
            r_cb     <= 1'b0;
            r_cbnz   <= 1'b0;
            r_bc     <= 1'b0;
            r_brr    <= 1'b0;
            r_flags  <= 1'b0;
            r_cond   <= 4'b0;
        end else begin
            state <= nxt;
            cnt   <= ((state == FETCH || state == MEM) && !mem_ready) ? cnt + 16'd1 : 16'd0;
            if (state == DECODE) begin
                k        <= k64[DATA_W-1:0];
                illegal  <= illegal | d_illegal;
                r_dp     <= c_dpi | c_dpr;
                r_ls     <= c_ls;
                r_store  <= c_ls & ~IR[22];
                r_uncond <= is_b;
                r_bl     <= is_b & IR[31];
                r_cb     <= is_cb;
                r_cbnz   <= IR[24];
                r_bc     <= is_bc;
                r_brr    <= is_brr;
                r_flags  <= d_flags;
                r_cond   <= IR[3:0];
            end
        end

    // strobes are gated by reset so they drop the instant reset asserts
    assign run         = reset;
    assign mem_req     = run && (state == FETCH || state == MEM);
    assign ir_load     = run && state == FETCH && mem_ready;
    assign mem_write   = run && state == MEM && r_store;
    assign reg_write   = run && ((state == EXEC && (r_dp || r_bl)) || state == WB);
    assign status_load = run && state == EXEC && r_flags;
    assign pc_sel      = (run && state == EXEC) ? (r_brr ? 2'b11 : taken ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_lev_multicycle_sequencer.sv
// tb_lev_multicycle_sequencer: directed bench with a per-instruction trace model and per-cycle compare
module tb_lev_multicycle_sequencer;
    localparam int TO = 15;
    localparam int K_DP = 0, K_BR = 1, K_LD = 2, K_ST = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, zero, mem_ready;
    logic [31:0] ir;
    logic [3:0] status;
    logic [2:0] state;
    logic mem_req, mem_write, ir_load, reg_write, status_load, illegal;
    logic [1:0] pc_sel;
    logic [63:0] k;

    logic reset2, mem_ready2;
    logic [31:0] ir2;
    logic [2:0] state2;
    logic mem_req2, mem_write2, ir_load2, reg_write2, status_load2, illegal2;
    logic [1:0] pc_sel2;
    logic [31:0] k2;

    lev_multicycle_sequencer #(.DATA_W(64), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .IR(ir), .status(status), .zero(zero), .mem_ready(mem_ready),
        .state(state), .mem_req(mem_req), .mem_write(mem_write), .ir_load(ir_load), .reg_write(reg_write),
        .status_load(status_load), .pc_sel(pc_sel), .k(k), .illegal(illegal));

    lev_multicycle_sequencer #(.DATA_W(32), .MEM_TIMEOUT(4)) dut32 (
        .clock(clock), .reset(reset2), .IR(ir2), .status(status), .zero(zero), .mem_ready(mem_ready2),
        .state(state2), .mem_req(mem_req2), .mem_write(mem_write2), .ir_load(ir_load2), .reg_write(reg_write2),
        .status_load(status_load2), .pc_sel(pc_sel2), .k(k2), .illegal(illegal2));

    typedef struct { logic [2:0] st; logic rq, wr, il, rw, sl; logic [1:0] pc; logic ck; logic [63:0] k; logic ill; } exp_t;
    typedef struct { int kind; logic rw, sl; logic [1:0] pc; logic [63:0] k; logic ill; } mdl_t;

    exp_t exp_q[$];
    exp_t e;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] cur_ir = 0;
    logic [3:0] cur_st = 0;
    logic cur_z = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic rq, wr, il, rw, sl,
                                input logic [1:0] pc, input logic ck, input logic [63:0] kv, input logic ill);
        exp_t r;
        r.st = st; r.rq = rq; r.wr = wr; r.il = il; r.rw = rw; r.sl = sl;
        r.pc = pc; r.ck = ck; r.k = kv; r.ill = ill;
        return r;
    endfunction

    // instruction-level reference: what EXEC must do and what k must be, from mnemonic opcodes
    function automatic mdl_t model(input logic [31:0] i, input logic [3:0] st, input logic z, input int dw);
        mdl_t m;
        logic n, zf, c, v, t;
        logic [1:0] hw;
        {n, zf, c, v} = st;
        m.kind = K_DP; m.rw = 1'b1; m.sl = 1'b0; m.pc = 2'b01; m.k = 64'd0; m.ill = 1'b0;
        if (i[31:21] == 11'b11010011011 || i[31:21] == 11'b11010011010) begin
            m.k = 64'(i[15:10]);
            m.ill = int'(i[15:10]) >= dw;
        end else if (i[31:23] == 9'b110100101 || i[31:23] == 9'b111100101) begin
            hw = i[22:21];
            m.k = 64'(i[20:5]) << (16 * hw);
            m.ill = dw == 32 && hw >= 2'd2;
        end else if (i[31:22] inside {10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
                                      10'b1001001000, 10'b1111001000, 10'b1011001000, 10'b1101001000}) begin
            m.k = 64'(i[21:10]);
            m.sl = i[31:22] inside {10'b1011000100, 10'b1111000100, 10'b1111001000};
        end else if (i[31:21] inside {11'b10001011000, 11'b10101011000, 11'b11001011000, 11'b11101011000,
                                      11'b10001010000, 11'b11101010000, 11'b10101010000, 11'b11001010000}) begin
            m.sl = i[31:21] inside {11'b10101011000, 11'b11101011000, 11'b11101010000};
        end else if (i[31:26] == 6'b000101 || i[31:26] == 6'b100101) begin
            m.kind = K_BR; m.rw = i[31]; m.pc = 2'b10;
            m.k = 64'($signed(i[25:0])) << 2;
        end else if (i[31:24] == 8'b10110100 || i[31:24] == 8'b10110101) begin
            m.kind = K_BR; m.rw = 1'b0;
            m.pc = (i[24] ? !z : z) ? 2'b10 : 2'b01;
            m.k = 64'($signed(i[23:5])) << 2;
        end else if (i[31:24] == 8'b01010100) begin
            case (i[3:0])
                4'd0: t = zf;             4'd1: t = !zf;
                4'd2: t = c;              4'd3: t = !c;
                4'd4: t = n;              4'd5: t = !n;
                4'd6: t = v;              4'd7: t = !v;
                4'd8: t = c && !zf;       4'd9: t = !(c && !zf);
                4'd10: t = n == v;        4'd11: t = n != v;
                4'd12: t = !zf && n == v; 4'd13: t = !(!zf && n == v);
                default: t = 1'b1;
            endcase
            m.kind = K_BR; m.rw = 1'b0; m.pc = t ? 2'b10 : 2'b01;
            m.k = 64'($signed(i[23:5])) << 2;
        end else if (i[31:21] == 11'b11010110000) begin
            m.kind = K_BR; m.rw = 1'b0; m.pc = 2'b11;
        end else if (i[31:21] == 11'b11111000010 || i[31:21] == 11'b11111000000) begin
            m.kind = i[22] ? K_LD : K_ST; m.rw = 1'b0;
            m.k = 64'($signed(i[20:12]));
        end else begin
            m.ill = 1'b1;
        end
        if (dw == 32) m.k = {32'b0, m.k[31:0]};
        return m;
    endfunction

    task automatic step(input logic rs, input logic rdy, input exp_t x);
        @(negedge clock);
        reset = rs; mem_ready = rdy; ir = cur_ir; status = cur_st; zero = cur_z;
        exp_q.push_back(x);
    endtask

    task automatic fault(input logic ill);
        repeat (3) step(1'b1, 1'b0, mk(3'd7, 0, 0, 0, 0, 0, 2'b00, 0, 64'd0, ill));
    endtask

    task automatic do_reset();
        repeat (2) step(1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 1, 64'd0, 0));
    endtask

    task automatic run(input logic [31:0] i, input logic [3:0] st, input logic z,
                       input int fw, input int mw, input bit abort);
        mdl_t m;
        logic w;
        m = model(i, st, z, 64);
        w = m.kind == K_ST;
        cur_ir = i; cur_st = st; cur_z = z;
        for (int f = 0; f < fw; f++) begin
            if (f == TO) begin fault(1'b0); return; end
            step(1'b1, 1'b0, mk(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 64'd0, 0));
        end
        step(1'b1, 1'b1, mk(3'd0, 1, 0, 1, 0, 0, 2'b00, 0, 64'd0, 0));
        step(1'b1, 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 64'd0, 0));
        if (m.ill) begin fault(1'b1); return; end
        step(1'b1, 1'b0, mk(3'd2, 0, 0, 0, m.rw, m.sl, m.pc, 1, m.k, 0));
        if (m.kind == K_LD || w) begin
            for (int j = 0; j < mw; j++) begin
                if (j == TO) begin fault(1'b0); return; end
                step(1'b1, 1'b0, mk(3'd3, 1, w, 0, 0, 0, 2'b00, 1, m.k, 0));
            end
            if (abort) return;
            step(1'b1, 1'b1, mk(3'd3, 1, w, 0, 0, 0, 2'b00, 1, m.k, 0));
            if (!w) step(1'b1, 1'b0, mk(3'd4, 0, 0, 0, 1, 0, 2'b00, 1, m.k, 0));
        end
    endtask

    always @(negedge clock) begin
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("state", state, e.st);
            chk("mem_req", mem_req, e.rq);
            chk("mem_write", mem_write, e.wr);
            chk("ir_load", ir_load, e.il);
            chk("reg_write", reg_write, e.rw);
            chk("status_load", status_load, e.sl);
            chk("pc_sel", pc_sel, e.pc);
            chk("illegal", illegal, e.ill);
            if (e.ck) chk("k", k, e.k);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] LSR  = {11'b11010011010, 5'd31, 6'd2, 5'd31, 5'd0};
    localparam logic [31:0] MOVK = {9'b111100101, 2'd3, 16'hBEEF, 5'd0};
    localparam logic [31:0] BGT  = {8'b01010100, 19'h7FFFF, 1'b0, 4'b1100};
    localparam logic [31:0] LDUR = {11'b11111000010, 9'h1F0, 2'b00, 5'd1, 5'd2};
    localparam logic [31:0] STUR = {11'b11111000000, 9'd24, 2'b00, 5'd1, 5'd3};

    initial begin
        logic [3:0] sts [3];
        sts[0] = 4'b1001; sts[1] = 4'b0110; sts[2] = 4'b0010;
        reset = 1'b0; mem_ready = 1'b0; ir = 0; status = 0; zero = 0;
        reset2 = 1'b0; mem_ready2 = 1'b0; ir2 = 0;

        chk("model lsr k", model(LSR, 4'b0, 1'b0, 64).k, 64'd2);
        chk("model movk k", model(MOVK, 4'b0, 1'b0, 64).k, 64'hBEEF_0000_0000_0000);
        chk("model movk32 illegal", model(MOVK, 4'b0, 1'b0, 32).ill, 1'b1);
        chk("model gt pc", model(BGT, 4'b0000, 1'b0, 64).pc, 2'b10);
        chk("model gt k", model(BGT, 4'b0000, 1'b0, 64).k, 64'hFFFF_FFFF_FFFF_FFFC);

        do_reset();
        run(LSR, 4'b0, 1'b0, 0, 0, 0);
        #2 chk("lsr k literal", k, 64'd2);
        run({10'b1011000100, 12'hFFF, 5'd1, 5'd2}, 4'b0, 1'b0, 1, 0, 0);
        run({11'b11101011000, 5'd3, 6'd0, 5'd1, 5'd2}, 4'b0, 1'b0, 0, 0, 0);
        run({11'b10101010000, 5'd3, 6'd0, 5'd1, 5'd2}, 4'b0, 1'b0, 0, 0, 0);
        run(MOVK, 4'b0, 1'b0, 0, 0, 0);
        #2 chk("movk k literal", k, 64'hBEEF_0000_0000_0000);
        run({9'b110100101, 2'd1, 16'h1234, 5'd7}, 4'b0, 1'b0, 0, 0, 0);
        run({11'b11010011011, 5'd0, 6'd63, 5'd0, 5'd0}, 4'b0, 1'b0, 0, 0, 0);
        run(BGT, 4'b0000, 1'b0, 0, 0, 0);
        #2 chk("gt taken pc literal", pc_sel, 2'b10);
        chk("gt k literal", k, 64'hFFFF_FFFF_FFFF_FFFC);
        run(BGT, 4'b0100, 1'b0, 0, 0, 0);
        #2 chk("gt not taken pc literal", pc_sel, 2'b01);
        for (int c = 0; c < 16; c++)
            for (int s = 0; s < 3; s++)
                run({8'b01010100, 19'd3, 1'b0, 4'(c)}, sts[s], 1'b0, 0, 0, 0);
        run({8'b10110100, 19'd5, 5'd0}, 4'b0, 1'b1, 0, 0, 0);
        run({8'b10110101, 19'd5, 5'd0}, 4'b0, 1'b1, 0, 0, 0);
        run({8'b10110101, 19'h7FFF0, 5'd0}, 4'b0, 1'b0, 0, 0, 0);
        run({6'b000101, 26'h3FFFFF0}, 4'b0, 1'b0, 0, 0, 0);
        run({6'b100101, 26'd100}, 4'b0, 1'b0, 0, 0, 0);
        run({11'b11010110000, 5'd31, 6'd0, 5'd30, 5'd0}, 4'b0, 1'b0, 0, 0, 0);
        run(LDUR, 4'b0, 1'b0, 0, 3, 0);
        run(STUR, 4'b0, 1'b0, 2, 0, 0);
        run(LDUR, 4'b0, 1'b0, TO - 1, TO - 1, 0);
        run(STUR, 4'b0, 1'b0, 0, 2, 1);
        do_reset();
        run({10'b1001000100, 12'd7, 5'd1, 5'd2}, 4'b0, 1'b0, 0, 0, 0);
        run({10'b1001000100, 12'd7, 5'd1, 5'd2}, 4'b0, 1'b0, TO + 5, 0, 0);
        do_reset();
        run(LDUR, 4'b0, 1'b0, 0, TO + 5, 0);
        do_reset();
        run(32'h0000_0000, 4'b0, 1'b0, 0, 0, 0);
        do_reset();
        run(STUR, 4'b0, 1'b0, 0, 0, 0);
        @(negedge clock);
        #3;

        ir2 = MOVK; mem_ready2 = 1'b1;
        @(negedge clock); reset2 = 1'b1;
        @(negedge clock); #2 chk("w32 decode state", state2, 3'd1);
        @(negedge clock); #2 chk("w32 movk state", state2, 3'd7);
        chk("w32 movk illegal", illegal2, 1'b1);
        @(negedge clock); reset2 = 1'b0; mem_ready2 = 1'b0;
        #2 chk("w32 reset state", state2, 3'd0);
        chk("w32 reset mem_req", mem_req2, 1'b0);
        chk("w32 reset illegal", illegal2, 1'b0);
        @(negedge clock); reset2 = 1'b1;
        repeat (3) @(negedge clock);
        #2 chk("w32 fetch wait state", state2, 3'd0);
        chk("w32 fetch wait mem_req", mem_req2, 1'b1);
        @(negedge clock); #2 chk("w32 timeout state", state2, 3'd7);
        chk("w32 timeout mem_req", mem_req2, 1'b0);
        mem_ready2 = 1'b1;
        @(negedge clock); #2 chk("w32 fault held", state2, 3'd7);
        chk("w32 fault ir_load", ir_load2, 1'b0);
        chk("w32 fault reg_write", reg_write2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
